// File: rtl/weak_sig_pkg.sv
// weak_sig_pkg: shared types, constants and helpers for the weak-signal AGC monitor
package weak_sig_pkg;
    typedef enum logic [1:0] {ACQUIRE, TRACK, LOCKED, OVERLOAD} state_t;
    localparam int SNR_W    = 8;
    localparam int AGC_STEP = 1;
    localparam int OVF_STEP = 2;
    // bit length of x: index of the highest set bit plus one, zero for zero
    function automatic logic [SNR_W-1:0] pos(input logic [63:0] x);
        pos = '0;
        for (int i = 0; i < 64; i++)
            if (x[i]) pos = SNR_W'(i + 1);
    endfunction
endpackage

// File: rtl/wsm_window_stats.sv
// wsm_window_stats: accumulate one sample into a channel slot and produce the window mean, deviation and peak
module wsm_window_stats #(
    parameter int MAG_WIDTH = 24,
    parameter int WIN_LOG2  = 8
) (
    input  logic [MAG_WIDTH-1:0]          mag,
    input  logic [WIN_LOG2-1:0]           cnt,
    input  logic [MAG_WIDTH+WIN_LOG2-1:0] sum,
    input  logic [MAG_WIDTH+WIN_LOG2-1:0] devsum,
    input  logic [MAG_WIDTH-1:0]          peak,
    input  logic [MAG_WIDTH-1:0]          prev_mean,
    output logic                          win_end,
    output logic [WIN_LOG2-1:0]           cnt_nxt,
    output logic [MAG_WIDTH+WIN_LOG2-1:0] sum_nxt,
    output logic [MAG_WIDTH+WIN_LOG2-1:0] devsum_nxt,
    output logic [MAG_WIDTH-1:0]          peak_nxt,
    output logic [MAG_WIDTH-1:0]          mean,
    output logic [MAG_WIDTH-1:0]          dev,
    output logic [MAG_WIDTH-1:0]          peak_win
);
    localparam int ACC_W = MAG_WIDTH + WIN_LOG2;
    logic [MAG_WIDTH-1:0] adev;
    logic [ACC_W-1:0]     sum_fin;
    logic [ACC_W-1:0]     dsum_fin;
    // fold the sample in; on the last sample of a window the slot is emptied for the next one
    always_comb begin
        adev       = mag >= prev_mean ? mag - prev_mean : prev_mean - mag;
        sum_fin    = sum + ACC_W'(mag);
        dsum_fin   = devsum + ACC_W'(adev);
        peak_win   = mag > peak ? mag : peak;
        win_end    = &cnt;
        mean       = sum_fin[ACC_W-1:WIN_LOG2];
        dev        = dsum_fin[ACC_W-1:WIN_LOG2];
        cnt_nxt    = cnt + WIN_LOG2'(1);
        sum_nxt    = win_end ? '0 : sum_fin;
        devsum_nxt = win_end ? '0 : dsum_fin;
        peak_nxt   = win_end ? '0 : peak_win;
    end
endmodule

// File: rtl/weak_signal_agc_monitor_mc.sv
// weak_signal_agc_monitor_mc: per-channel AGC, SNR estimate and lock qualification over a shared magnitude stream
module weak_signal_agc_monitor_mc
    import weak_sig_pkg::*;
#(
    parameter int                   NUM_CH       = 4,
    parameter int                   CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int                   MAG_WIDTH    = 24,
    parameter int                   GAIN_WIDTH   = 4,
    parameter int                   WIN_LOG2     = 8,
    parameter int                   INIT_GAIN    = 4,
    parameter logic [MAG_WIDTH-1:0] LO_THRESH    = 24'h010000,
    parameter logic [MAG_WIDTH-1:0] HI_THRESH    = 24'h700000,
    parameter logic [MAG_WIDTH-1:0] OVF_THRESH   = 24'h780000,
    parameter int                   LOCK_SNR     = 8,
    parameter int                   LOCK_WINDOWS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [MAG_WIDTH-1:0]         mag_in,
    input  logic [CH_W-1:0]              mag_ch,
    input  logic                         mag_valid,
    input  logic                         cfg_agc_en,
    input  logic [GAIN_WIDTH-1:0]        cfg_manual_gain,
    output logic [NUM_CH*GAIN_WIDTH-1:0] gain_out,
    output logic [NUM_CH-1:0]            lock_out,
    output logic [NUM_CH-1:0]            overload_out,
    output logic                         stat_valid,
    output logic [CH_W-1:0]              stat_ch,
    output logic [MAG_WIDTH-1:0]         stat_mean,
    output logic [MAG_WIDTH-1:0]         stat_dev,
    output logic [SNR_W-1:0]             stat_snr,
    output logic                         err_bad_ch
);
    localparam int ACC_W = MAG_WIDTH + WIN_LOG2;
    localparam int GC_W  = $clog2(LOCK_WINDOWS + 1);
    localparam logic [GAIN_WIDTH-1:0]   GAIN_MAX = '1;
    localparam logic [GAIN_WIDTH-1:0]   G_AGC    = GAIN_WIDTH'(AGC_STEP);
    localparam logic [GAIN_WIDTH-1:0]   G_OVF    = GAIN_WIDTH'(OVF_STEP);
    localparam logic signed [SNR_W-1:0] SNR_LOCK = SNR_W'(LOCK_SNR);
    localparam logic signed [SNR_W-1:0] SNR_HOLD = SNR_W'(LOCK_SNR - 1);

    logic [WIN_LOG2-1:0]   cnt_q   [NUM_CH];
    logic [ACC_W-1:0]      sum_q   [NUM_CH];
    logic [ACC_W-1:0]      dsum_q  [NUM_CH];
    logic [MAG_WIDTH-1:0]  peak_q  [NUM_CH];
    logic [MAG_WIDTH-1:0]  pmean_q [NUM_CH];
    logic [GC_W-1:0]       gc_q    [NUM_CH];
    logic [GAIN_WIDTH-1:0] gain_q  [NUM_CH];
    state_t                st_q    [NUM_CH];
    logic [NUM_CH-1:0]     settle_q;

    logic                  s1_v;
    logic [CH_W-1:0]       s1_ch;
    logic [MAG_WIDTH-1:0]  s1_mag;

    logic                  in_bad, in_ok, win_end, eval, settle_set, out_band;
    logic [WIN_LOG2-1:0]   cnt_nxt;
    logic [ACC_W-1:0]      sum_nxt, dsum_nxt;
    logic [MAG_WIDTH-1:0]  peak_nxt, mean, dev, peak_win;
    logic signed [SNR_W-1:0] snr;
    logic [GAIN_WIDTH-1:0] e_gain, step_gain, n_gain;
    logic [GC_W-1:0]       e_gc, gc_inc, n_gc;
    state_t                e_st, n_st;

    assign in_bad     = mag_valid && (32'(mag_ch) >= NUM_CH);
    assign in_ok      = mag_valid && !in_bad;
    assign eval       = s1_v && win_end && !settle_q[s1_ch];
    assign settle_set = cfg_agc_en && (n_gain != e_gain);

    wsm_window_stats #(.MAG_WIDTH(MAG_WIDTH), .WIN_LOG2(WIN_LOG2)) u_stats (
        .mag        (s1_mag),
        .cnt        (cnt_q[s1_ch]),
        .sum        (sum_q[s1_ch]),
        .devsum     (dsum_q[s1_ch]),
        .peak       (peak_q[s1_ch]),
        .prev_mean  (pmean_q[s1_ch]),
        .win_end    (win_end),
        .cnt_nxt    (cnt_nxt),
        .sum_nxt    (sum_nxt),
        .devsum_nxt (dsum_nxt),
        .peak_nxt   (peak_nxt),
        .mean       (mean),
        .dev        (dev),
        .peak_win   (peak_win)
    );

    // state register: only the channel whose window is evaluated this cycle moves
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) st_q[c] <= ACQUIRE;
        end else if (eval) begin
            st_q[s1_ch] <= n_st;
        end
    end

    // next state, gain and good-window count for the evaluated channel; overload wins over everything
    always_comb begin
        e_gain    = gain_q[s1_ch];
        e_st      = st_q[s1_ch];
        e_gc      = gc_q[s1_ch];
        out_band  = (mean < LO_THRESH) || (mean > HI_THRESH);
        step_gain = (mean < LO_THRESH && e_gain != GAIN_MAX) ? e_gain + G_AGC :
                    (mean > HI_THRESH && e_gain != '0) ? e_gain - G_AGC : e_gain;
        snr       = pos(64'(mean)) - pos(64'(dev));
        gc_inc    = e_gc + GC_W'(1);
        n_st      = e_st;
        n_gain    = e_gain;
        n_gc      = e_gc;
        if (peak_win >= OVF_THRESH) begin
            n_st   = OVERLOAD;
            n_gain = e_gain > G_OVF ? e_gain - G_OVF : '0;
        end else begin
            case (e_st)
                ACQUIRE: begin
                    n_gain = step_gain;
                    n_st   = step_gain == e_gain ? TRACK : ACQUIRE;
                    n_gc   = '0;
                end
                TRACK: begin
                    if (out_band) begin
                        n_st   = ACQUIRE;
                        n_gain = step_gain;
                    end else if (snr >= SNR_LOCK) begin
                        n_gc = gc_inc;
                        if (gc_inc == GC_W'(LOCK_WINDOWS)) n_st = LOCKED;
                    end else begin
                        n_gc = '0;
                    end
                end
                LOCKED: begin
                    if (out_band || snr < SNR_HOLD) begin
                        n_st = TRACK;
                        n_gc = '0;
                    end
                end
                default: n_st = ACQUIRE;
            endcase
        end
    end

    // flags follow the stored state; gains are packed with channel 0 in the LSBs
    always_comb begin
        gain_out     = '0;
        lock_out     = '0;
        overload_out = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            gain_out[c*GAIN_WIDTH +: GAIN_WIDTH] = gain_q[c];
            lock_out[c]     = st_q[c] == LOCKED;
            overload_out[c] = st_q[c] == OVERLOAD;
        end
    end

    // sample capture, single-cycle read-modify-write of the channel slot, gains and stat outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v       <= 1'b0;
            s1_ch      <= '0;
            s1_mag     <= '0;
            err_bad_ch <= 1'b0;
            stat_valid <= 1'b0;
            stat_ch    <= '0;
            stat_mean  <= '0;
            stat_dev   <= '0;
            stat_snr   <= '0;
            settle_q   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c]   <= '0;
                sum_q[c]   <= '0;
                dsum_q[c]  <= '0;
                peak_q[c]  <= '0;
                pmean_q[c] <= '0;
                gc_q[c]    <= '0;
                gain_q[c]  <= GAIN_WIDTH'(INIT_GAIN);
            end
        end else begin
            s1_v       <= in_ok;
            err_bad_ch <= err_bad_ch | in_bad;
            stat_valid <= eval;
            if (in_ok) begin
                s1_ch  <= mag_ch;
                s1_mag <= mag_in;
            end
            if (eval) begin
                stat_ch   <= s1_ch;
                stat_mean <= mean;
                stat_dev  <= dev;
                stat_snr  <= snr;
            end
            if (!cfg_agc_en)
                for (int c = 0; c < NUM_CH; c++) gain_q[c] <= cfg_manual_gain;
            if (s1_v) begin
                cnt_q[s1_ch]  <= cnt_nxt;
                sum_q[s1_ch]  <= sum_nxt;
                dsum_q[s1_ch] <= dsum_nxt;
                peak_q[s1_ch] <= peak_nxt;
                if (win_end) begin
                    pmean_q[s1_ch]  <= mean;
                    settle_q[s1_ch] <= eval && settle_set;
                end
                if (eval) begin
                    gc_q[s1_ch] <= n_gc;
                    if (cfg_agc_en) gain_q[s1_ch] <= n_gain;
                end
            end
        end
    end
endmodule

// File: tb/tb_weak_signal_agc_monitor_mc.sv
// tb_weak_signal_agc_monitor_mc: randomized scoreboard bench against a window-level reference model
module tb_weak_signal_agc_monitor_mc;
    logic        clk = 0, rst = 0;
    logic [23:0] mag_in = 0;
    logic [1:0]  mag_ch = 0;
    logic        mag_valid = 0, cfg_agc_en = 1;
    logic [3:0]  cfg_manual_gain = 0;
    logic [15:0] gain_out;
    logic [3:0]  lock_out, overload_out;
    logic        stat_valid, err_bad_ch;
    logic [1:0]  stat_ch;
    logic [23:0] stat_mean, stat_dev;
    logic [7:0]  stat_snr;

    logic [23:0] b_mag_in = 0;
    logic [2:0]  b_mag_ch = 0;
    logic        b_valid = 0;
    logic [19:0] b_gain;
    logic [4:0]  b_lock, b_ovl;
    logic        b_stat_valid, b_err;
    logic [2:0]  b_stat_ch;
    logic [23:0] b_mean, b_dev;
    logic [7:0]  b_snr;

    typedef struct {int ch; longint mean; longint dev; int snr; int gain; int lock; int ovl;} exp_t;
    exp_t   expq[$];
    exp_t   mon_e;
    longint win[4][$];
    longint m_pm[4];
    int     m_gain[4], m_st[4], m_gc[4];
    bit     m_settle[4];
    bit     m_agc = 1;
    int     m_man = 0;
    logic [23:0] lvl[4], nz[4];
    int     n_tests = 0, n_fail = 0, b_stat_seen = 0;

    weak_signal_agc_monitor_mc #(.NUM_CH(4), .WIN_LOG2(4)) dut (
        .clk(clk), .rst(rst), .mag_in(mag_in), .mag_ch(mag_ch), .mag_valid(mag_valid),
        .cfg_agc_en(cfg_agc_en), .cfg_manual_gain(cfg_manual_gain), .gain_out(gain_out),
        .lock_out(lock_out), .overload_out(overload_out), .stat_valid(stat_valid),
        .stat_ch(stat_ch), .stat_mean(stat_mean), .stat_dev(stat_dev), .stat_snr(stat_snr),
        .err_bad_ch(err_bad_ch)
    );

    weak_signal_agc_monitor_mc #(.NUM_CH(5), .WIN_LOG2(4)) dut5 (
        .clk(clk), .rst(rst), .mag_in(b_mag_in), .mag_ch(b_mag_ch), .mag_valid(b_valid),
        .cfg_agc_en(cfg_agc_en), .cfg_manual_gain(cfg_manual_gain), .gain_out(b_gain),
        .lock_out(b_lock), .overload_out(b_ovl), .stat_valid(b_stat_valid),
        .stat_ch(b_stat_ch), .stat_mean(b_mean), .stat_dev(b_dev), .stat_snr(b_snr),
        .err_bad_ch(b_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int bitlen(longint x);
        int n = 0;
        while (x > 0) begin
            x = x >> 1;
            n++;
        end
        return n;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < 4; c++) begin
            win[c].delete();
            m_pm[c] = 0; m_gain[c] = 4; m_st[c] = 0; m_gc[c] = 0; m_settle[c] = 0;
        end
        expq.delete();
    endfunction

    // window-level model: states 0=acquire 1=track 2=locked 3=overload
    function automatic void model_sample(int ch, longint m);
        longint sum = 0, dsum = 0, pk = 0, mean, dev;
        int old, step, snr;
        bit lo, hi;
        exp_t e;
        win[ch].push_back(m);
        if (win[ch].size() < 16) return;
        for (int i = 0; i < 16; i++) begin
            sum  += win[ch][i];
            dsum += (win[ch][i] > m_pm[ch]) ? win[ch][i] - m_pm[ch] : m_pm[ch] - win[ch][i];
            if (win[ch][i] > pk) pk = win[ch][i];
        end
        win[ch].delete();
        mean = sum / 16;
        dev  = dsum / 16;
        m_pm[ch] = mean;
        if (m_settle[ch]) begin
            m_settle[ch] = 0;
            return;
        end
        old  = m_gain[ch];
        lo   = mean < 'h10000;
        hi   = mean > 'h700000;
        step = (lo && old < 15) ? 1 : (hi && old > 0) ? -1 : 0;
        snr  = bitlen(mean) - bitlen(dev);
        if (pk >= 'h780000) begin
            m_st[ch] = 3;
            m_gain[ch] = (old >= 2) ? old - 2 : 0;
        end else if (m_st[ch] == 0) begin
            if (step != 0) m_gain[ch] = old + step;
            else begin m_st[ch] = 1; m_gc[ch] = 0; end
        end else if (m_st[ch] == 1) begin
            if (lo || hi) begin m_st[ch] = 0; m_gain[ch] = old + step; end
            else if (snr >= 8) begin m_gc[ch]++; if (m_gc[ch] == 4) m_st[ch] = 2; end
            else m_gc[ch] = 0;
        end else if (m_st[ch] == 2) begin
            if (lo || hi || snr < 7) begin m_st[ch] = 1; m_gc[ch] = 0; end
        end else begin
            m_st[ch] = 0;
        end
        if (!m_agc) m_gain[ch] = old;
        m_settle[ch] = m_agc && m_gain[ch] != old;
        e.ch = ch; e.mean = mean; e.dev = dev; e.snr = snr; e.gain = m_gain[ch];
        e.lock = int'(m_st[ch] == 2); e.ovl = int'(m_st[ch] == 3);
        expq.push_back(e);
    endfunction

    task automatic send(input int ch, input logic [23:0] m);
        @(negedge clk);
        mag_valid = 1'b1;
        mag_ch = 2'(ch);
        mag_in = m;
        model_sample(ch, longint'(m));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            mag_valid = 1'b0;
        end
    endtask

    task automatic send_win(input int ch, input logic [23:0] m);
        for (int i = 0; i < 16; i++) send(ch, m);
    endtask

    task automatic rand_traffic(input int n);
        logic [23:0] levels[6] = '{24'h000100, 24'h008000, 24'h200000, 24'h400000, 24'h6F0000, 24'h7A0000};
        logic [23:0] noises[4] = '{24'h0, 24'hFF, 24'hFFFF, 24'h3FFFF};
        int ch;
        for (int i = 0; i < n; i++) begin
            if (i % 100 == 0)
                for (int c = 0; c < 4; c++) begin
                    lvl[c] = levels[$urandom_range(0, 5)];
                    nz[c]  = noises[$urandom_range(0, 3)];
                end
            if ($urandom_range(0, 7) == 0) idle(1);
            else begin
                ch = $urandom_range(0, 3);
                send(ch, lvl[ch] + (24'($urandom) & nz[ch]));
            end
        end
    endtask

    // scoreboard monitor: every stat pulse is matched against the oldest expected window
    initial forever begin
        @(negedge clk);
        if (stat_valid) begin
            chk("stat_expected", longint'(expq.size() > 0), 1);
            if (expq.size() > 0) begin
                mon_e = expq.pop_front();
                chk("stat_ch", stat_ch, mon_e.ch);
                chk("stat_mean", stat_mean, mon_e.mean);
                chk("stat_dev", stat_dev, mon_e.dev);
                chk("stat_snr", longint'($signed(stat_snr)), mon_e.snr);
                chk("gain", gain_out[mon_e.ch*4 +: 4], mon_e.gain);
                chk("lock", lock_out[mon_e.ch], mon_e.lock);
                chk("overload", overload_out[mon_e.ch], mon_e.ovl);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (b_stat_valid) b_stat_seen++;
    end

    initial begin
        model_reset();
        #1 rst = 1;
        repeat (2) @(negedge clk);
        chk("rst_gain", gain_out, 'h4444);
        chk("rst_lock", lock_out, 0);
        chk("rst_ovl", overload_out, 0);
        chk("rst_stat_valid", stat_valid, 0);
        chk("rst_err", err_bad_ch, 0);
        chk("rst_b_err", b_err, 0);
        rst = 0;
        // low level: raise, settle window, raise again
        send_win(0, 24'h000100);
        send_win(0, 24'h000100);
        send_win(0, 24'h000100);
        // lock on ch1, lose it through deviation, regain it
        for (int w = 0; w < 5; w++) send_win(1, 24'h200000);
        for (int i = 0; i < 16; i++) send(1, (i % 2) ? 24'h300000 : 24'h100000);
        for (int w = 0; w < 4; w++) send_win(1, 24'h200000);
        idle(3);
        chk("lock_regained", lock_out[1], 1);
        // reset in the middle of a ch0 window
        for (int i = 0; i < 7; i++) send(0, 24'h123456);
        @(negedge clk);
        mag_valid = 0;
        rst = 1;
        #1;
        chk("mid_rst_gain", gain_out, 'h4444);
        chk("mid_rst_lock", lock_out, 0);
        chk("mid_rst_stat_valid", stat_valid, 0);
        model_reset();
        @(negedge clk);
        rst = 0;
        send_win(0, 24'h000100);
        // overload on ch2, settle window, clean recovery
        for (int i = 0; i < 16; i++) send(2, (i == 8) ? 24'h7F0000 : 24'h200000);
        send_win(2, 24'h200000);
        send_win(2, 24'h200000);
        // ch0/ch3 interleave, then ch0 back-to-back across a window boundary
        for (int i = 0; i < 64; i++) send((i % 2) ? 3 : 0, 24'($urandom_range(0, 24'h3FFFFF)));
        for (int i = 0; i < 32; i++) send(0, 24'($urandom_range(0, 24'h3FFFFF)));
        rand_traffic(900);
        // manual gain
        idle(4);
        cfg_agc_en = 0;
        cfg_manual_gain = 4'd9;
        m_agc = 0;
        for (int c = 0; c < 4; c++) m_gain[c] = 9;
        @(negedge clk);
        chk("manual_gain", gain_out, 'h9999);
        rand_traffic(300);
        idle(4);
        cfg_agc_en = 1;
        m_agc = 1;
        rand_traffic(300);
        // bad channel on the five-channel instance
        idle(4);
        chk("b_err_before", b_err, 0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            b_valid = 1; b_mag_ch = 3'd5; b_mag_in = 24'h000100;
        end
        @(negedge clk);
        b_valid = 0;
        idle(4);
        chk("b_err_set", b_err, 1);
        chk("b_no_stat", b_stat_seen, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            b_valid = 1; b_mag_ch = 3'd1; b_mag_in = 24'h000200;
        end
        @(negedge clk);
        b_valid = 0;
        idle(2);
        chk("b_err_sticky", b_err, 1);
        chk("main_err_clear", err_bad_ch, 0);
        idle(6);
        chk("drain", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
